// File: rtl/logit_search.sv
// rtl/logit_search.sv - inverse sigmoid by 8-step bisection over one Q3.4 -> Q0.7 sigmoid LUT
// Optional saturated-result counter enabled by LOGIT_SAT_CNT_EN.
module logit_search
`ifdef LOGIT_SAT_CNT_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_x,
  output logic       out_sat
`ifdef LOGIT_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0] sat_count
`endif
);

  typedef enum logic [1:0] {IDLE, SEARCH, CHECK, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] y_q, y_d;
  logic [7:0] p_q, p_d;
  logic [2:0] b_q, b_d;
  logic [7:0] x_q, x_d;
  logic       sat_q, sat_d;

  logic [7:0] t;
  logic [7:0] lut_idx;
  logic [7:0] lut_val;
  logic       lut_lt;

  // Rounded 128*sigmoid(a/16) for magnitude a in 0..128, before clamping to 127.
  function automatic logic [7:0] sig_mag(input logic [7:0] a);
    logic [7:0] r;
    r = 8'd128;
    case (a) inside
      [8'd0:8'd9]:   r = 8'd64 + (a << 1);
      8'd10:         r = 8'd83;
      8'd11:         r = 8'd85;
      8'd12:         r = 8'd87;
      8'd13:         r = 8'd89;
      8'd14:         r = 8'd90;
      8'd15:         r = 8'd92;
      8'd16:         r = 8'd94;
      8'd17:         r = 8'd95;
      8'd18:         r = 8'd97;
      8'd19:         r = 8'd98;
      8'd20:         r = 8'd99;
      8'd21:         r = 8'd101;
      8'd22:         r = 8'd102;
      8'd23:         r = 8'd103;
      8'd24:         r = 8'd105;
      [8'd25:8'd33]: r = 8'd81 + a;
      8'd34:         r = 8'd114;
      8'd35:         r = 8'd115;
      [8'd36:8'd37]: r = 8'd116;
      8'd38:         r = 8'd117;
      [8'd39:8'd40]: r = 8'd118;
      [8'd41:8'd42]: r = 8'd119;
      [8'd43:8'd44]: r = 8'd120;
      [8'd45:8'd46]: r = 8'd121;
      [8'd47:8'd49]: r = 8'd122;
      [8'd50:8'd52]: r = 8'd123;
      [8'd53:8'd57]: r = 8'd124;
      [8'd58:8'd62]: r = 8'd125;
      [8'd63:8'd70]: r = 8'd126;
      [8'd71:8'd88]: r = 8'd127;
      default:       r = 8'd128;
    endcase
    return r;
  endfunction

  // Negative inputs use the point symmetry sigmoid(-x) = 1 - sigmoid(x).
  function automatic logic [7:0] sigmoid_q07(input logic [7:0] x);
    logic [7:0] g;
    if (!x[7]) begin
      g = sig_mag(x);
      return g[7] ? 8'd127 : g;
    end
    g = sig_mag(8'd0 - x);
    return 8'd128 - g;
  endfunction

  assign t       = p_q + (8'd1 << b_q);
  assign lut_idx = (state_q == SEARCH) ? (t - 8'd1) : p_q;
  assign lut_val = sigmoid_q07(lut_idx ^ 8'h80);
  assign lut_lt  = (lut_val < y_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_x     = x_q;
  assign out_sat   = sat_q;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    p_d     = p_q;
    b_d     = b_q;
    x_d     = x_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = in_y;
          p_d     = 8'd0;
          b_d     = 3'd7;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (lut_lt) p_d = t;
        if (b_q == 3'd0) state_d = CHECK;
        else             b_d = b_q - 3'd1;
      end
      CHECK: begin
        sat_d   = lut_lt;
        x_d     = lut_lt ? 8'h7F : (p_q ^ 8'h80);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= 8'd0;
      p_q     <= 8'd0;
      b_q     <= 3'd0;
      x_q     <= 8'd0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      p_q     <= p_d;
      b_q     <= b_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
    end
  end

`ifdef LOGIT_SAT_CNT_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if ((state_q == DONE) && out_ready && sat_q && (sat_cnt_q != {CNT_W{1'b1}}))
      sat_cnt_d = sat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule
